// File: rtl/instruction_fetch.sv
// Instruction fetch front end: drives the fetch PC to a 1-cycle synchronous instruction
// memory, tracks the single outstanding read and buffers {pc, instr} in a 2-entry queue.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] i_addr,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_ent_t;

  logic [31:0] r_fetch_pc;
  logic [31:0] r_inflight_pc;
  logic        r_inflight;
  fetch_ent_t  r_q [BUF_DEPTH];
  logic        r_head;
  logic [1:0]  r_count;

  logic        w_resp_live;
  logic        w_deq;
  logic        w_q_deq;
  logic        w_enq;
  logic        w_issue;
  logic        w_tail;
  logic [2:0]  w_occ;
  fetch_ent_t  w_head_ent;
  logic [1:0]  w_unused_pc_lo;

  assign w_unused_pc_lo = redirect_pc[1:0];
  assign i_addr         = r_fetch_pc;
  assign w_resp_live    = r_inflight && !redirect_valid;
  assign w_head_ent     = r_q[r_head];
  // The tail only advances past the head when one entry is held; at count 2 nothing enqueues.
  assign w_tail         = r_head ^ r_count[0];

  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_instr = '0;
    if (!redirect_valid) begin
      if (r_count != 2'd0) begin
        out_valid = 1'b1;
        out_pc    = w_head_ent.pc;
        out_instr = w_head_ent.instr;
      end else if (r_inflight) begin
        out_valid = 1'b1;
        out_pc    = r_inflight_pc;
        out_instr = instruction;
      end
    end
  end

  assign w_deq   = out_valid && out_ready;
  assign w_q_deq = w_deq && (r_count != 2'd0);
  assign w_enq   = w_resp_live && !((r_count == 2'd0) && w_deq);
  // Slots that will be occupied next cycle before this cycle's issue is counted.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_deq};
  assign w_issue = !redirect_valid && (w_occ < 3'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_head        <= 1'b0;
      r_count       <= 2'd0;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 32'd4;
      end
      if (w_q_deq) r_head <= ~r_head;
      r_count <= r_count + {1'b0, w_enq} - {1'b0, w_q_deq};
    end
  end

  // Payload storage carries no reset; validity is tracked entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_enq) r_q[w_tail] <= '{pc: r_inflight_pc, instr: instruction};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (({1'b0, r_count} + {2'b00, r_inflight}) <= 3'd2));

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: aliasing 64-word synchronous memory, scoreboard of expected
// {pc, instr} deliveries popped on each handshake, plus cycle-exact checks per scenario.
module tb_instruction_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_addr;
  logic [31:0] instruction;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [64];
  int          n_chk = 0;
  int          n_err = 0;

  instruction_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .i_addr(i_addr), .instruction(instruction),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  // Memory aliases every 256 bytes, so 0xFFFF_FFF8 maps to word 62.
  always @(posedge clk) instruction <= mem[i_addr[7:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem[pc[7:2]];
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("xfer_expected", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("xfer_pc", out_pc, e.pc);
        chk("xfer_instr", out_instr, e.instr);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic start(input logic rdy);
    nxt();
    reset     = 1'b0;
    out_ready = rdy;
  endtask

  task automatic hold_reset(input string tag);
    nxt();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    #1;
    chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
    chk({tag, "_rst_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rst_addr"}, i_addr, RST_PC);
    sb.delete();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    mem[0]  = 32'h0000_0013;
    mem[1]  = 32'h0010_0093;
    mem[2]  = 32'h0020_0113;
    mem[3]  = 32'h0030_0193;
    mem[16] = 32'hDEAD_BEEF;

    nxt(); nxt(); neg();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", i_addr, RST_PC);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_instr", out_instr, 32'd0);

    // Streaming from reset.
    push(0); push(4); push(8); push(12);
    start(1'b1); neg();
    chk("p1_c0_valid", 32'(out_valid), 32'd0);
    chk("p1_c0_addr", i_addr, RST_PC);
    for (int k = 1; k <= 4; k++) begin
      nxt(); neg();
      chk("p1_stream_valid", 32'(out_valid), 32'd1);
    end
    hold_reset("p1");

    // Backpressure from the first valid, then release.
    push(0); push(4); push(8);
    start(1'b0); neg();
    nxt(); neg();
    chk("p2_first_valid", 32'(out_valid), 32'd1);
    chk("p2_first_pc", out_pc, 32'd0);
    nxt(); neg();
    for (int k = 3; k <= 5; k++) begin
      nxt(); neg();
      chk("p2_hold_addr", i_addr, 32'd8);
      chk("p2_hold_pc", out_pc, 32'd0);
      chk("p2_hold_valid", 32'(out_valid), 32'd1);
    end
    nxt(); out_ready = 1'b1; neg();
    nxt(); neg();
    nxt(); neg();
    hold_reset("p2");

    // Redirect to 0x40 while 0x10 is returning.
    push(0); push(4); push(8); push(12); push(32'h40); push(32'h44); push(32'h48);
    start(1'b1); neg();
    for (int k = 1; k <= 4; k++) begin nxt(); neg(); end
    nxt(); redirect_valid = 1'b1; redirect_pc = 32'h40; neg();
    chk("p3_redir_valid", 32'(out_valid), 32'd0);
    chk("p3_redir_addr", i_addr, 32'h14);
    nxt(); redirect_valid = 1'b0; neg();
    chk("p3_n1_addr", i_addr, 32'h40);
    chk("p3_n1_valid", 32'(out_valid), 32'd0);
    nxt(); neg();
    chk("p3_n2_valid", 32'(out_valid), 32'd1);
    chk("p3_n2_instr", out_instr, 32'hDEAD_BEEF);
    nxt(); neg();
    nxt(); neg();
    hold_reset("p3");

    // Misaligned redirect while the queue is full.
    push(32'h40); push(32'h44);
    start(1'b0); neg();
    nxt(); neg();
    nxt(); neg();
    nxt(); neg();
    chk("p4_full_addr", i_addr, 32'd8);
    chk("p4_full_valid", 32'(out_valid), 32'd1);
    nxt(); redirect_valid = 1'b1; redirect_pc = 32'h43; neg();
    chk("p4_redir_valid", 32'(out_valid), 32'd0);
    nxt(); redirect_valid = 1'b0; out_ready = 1'b1; neg();
    chk("p4_n1_addr", i_addr, 32'h40);
    chk("p4_n1_valid", 32'(out_valid), 32'd0);
    nxt(); neg();
    chk("p4_n2_valid", 32'(out_valid), 32'd1);
    nxt(); neg();
    hold_reset("p4");

    // Back-to-back redirects, the last one into the address wrap.
    push(32'hFFFF_FFF8); push(32'hFFFF_FFFC); push(0); push(4);
    start(1'b1); neg();
    nxt(); redirect_valid = 1'b1; redirect_pc = 32'h80; neg();
    chk("p5_r1_valid", 32'(out_valid), 32'd0);
    nxt(); redirect_pc = 32'hFFFF_FFF8; neg();
    chk("p5_r2_addr", i_addr, 32'h80);
    chk("p5_r2_valid", 32'(out_valid), 32'd0);
    nxt(); redirect_valid = 1'b0; neg();
    chk("p5_n1_addr", i_addr, 32'hFFFF_FFF8);
    chk("p5_n1_valid", 32'(out_valid), 32'd0);
    nxt(); neg();
    nxt(); neg();
    chk("p5_wrap_addr", i_addr, 32'h0);
    nxt(); neg();
    nxt(); neg();
    hold_reset("p5");

    // Asynchronous reset mid-stream with a full queue.
    start(1'b0); neg();
    for (int k = 1; k <= 4; k++) begin nxt(); neg(); end
    chk("p6_full_addr", i_addr, 32'd8);
    #1 reset = 1'b1;
    #1;
    chk("p6_async_valid", 32'(out_valid), 32'd0);
    chk("p6_async_addr", i_addr, RST_PC);
    push(0); push(4);
    start(1'b1); neg();
    chk("p6_c0_valid", 32'(out_valid), 32'd0);
    nxt(); neg();
    chk("p6_c1_valid", 32'(out_valid), 32'd1);
    nxt(); neg();
    hold_reset("p6");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
